// File: rtl/cic_interpolator.sv
// cic_interpolator
//   N-stage CIC interpolator (differential delay 1) with power-of-two factor R,
//   gain normalised to unity by an arithmetic right shift, saturated output.
//   One low-rate sample is taken over valid/ready every R clocks. One output
//   sample is produced every clock once the pipeline has filled.
//   Optional feature macro: CIC_INT_ROUND_EN. When defined, the normalising
//   shift rounds half-up. When undefined, the shift truncates toward -inf.
// Ports
//   CLK                       system clock, rising edge
//   RST                       asynchronous reset, active low
//   filter_enable             0 clears everything synchronously back to IDLE
//   CIC_Interpolation_Factor  R, legal values 1,2,4,8,16
//   in_data / in_valid        low-rate input sample and its valid flag
//   in_ready                  input accepted this cycle (combinational)
//   out_data / out_valid      interpolated sample, valid every RUN cycle once filled
//   underrun                  one-cycle pulse when a zero replaced a missing sample
//   factor_err                R is illegal (combinational level)
module cic_interpolator #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N_STAGES   = 3,
    parameter int unsigned LOG2_MAX_R = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  filter_enable,
    input  logic [4:0]            CIC_Interpolation_Factor,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  underrun,
    output logic                  factor_err
);

    localparam int unsigned W_ACC  = DATA_WIDTH + N_STAGES * LOG2_MAX_R;
    localparam int unsigned PH_W   = LOG2_MAX_R;
    localparam int unsigned LR_W   = $clog2(LOG2_MAX_R + 1);
    localparam int unsigned SH_W   = $clog2(W_ACC);
    localparam int unsigned FILL_W = $clog2(N_STAGES + 1);
    localparam logic signed [W_ACC-1:0] SAT_MAX =
        {{(W_ACC-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [W_ACC-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                  r_state;
    logic [LR_W-1:0]         r_log2r;
    logic [PH_W-1:0]         r_phase;
    logic [FILL_W-1:0]       r_fill;
    logic signed [W_ACC-1:0] r_comb_dly [N_STAGES];
    logic signed [W_ACC-1:0] r_u;
    logic signed [W_ACC-1:0] r_int [N_STAGES];

    logic                    w_fact_ok;
    logic [LR_W-1:0]         w_fact_log2;
    logic [PH_W-1:0]         w_ph_max;
    logic                    w_ph_last;
    logic                    w_accept;
    logic                    w_comb_clk;
    logic signed [W_ACC-1:0] w_comb [N_STAGES+1];
    logic [SH_W-1:0]         w_shift;
    logic signed [W_ACC-1:0] w_round;
    logic signed [W_ACC-1:0] w_shifted;
    logic [DATA_WIDTH-1:0]   w_sat;

    // Factor decode: legal only for an exact power of two up to 2^LOG2_MAX_R
    always_comb begin
        w_fact_ok   = 1'b0;
        w_fact_log2 = '0;
        for (int i = 0; i <= int'(LOG2_MAX_R); i++) begin
            if (CIC_Interpolation_Factor == 5'(1 << i)) begin
                w_fact_ok   = 1'b1;
                w_fact_log2 = LR_W'(i);
            end
        end
    end

    assign factor_err = !w_fact_ok;

    // Phase wraps at R-1 of the R latched on entry to RUN
    assign w_ph_max   = ~({PH_W{1'b1}} << r_log2r);
    assign w_ph_last  = (r_phase == w_ph_max);
    assign in_ready   = filter_enable && w_fact_ok && ((r_state == IDLE) || w_ph_last);
    assign w_accept   = in_valid && in_ready;
    assign w_comb_clk = (r_state == IDLE) ? w_accept : w_ph_last;

    // Comb chain is combinational; only its delay taps are registered
    always_comb begin
        w_comb[0] = w_accept ? {{(W_ACC-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data} : '0;
        for (int k = 0; k < int'(N_STAGES); k++) begin
            w_comb[k+1] = w_comb[k] - r_comb_dly[k];
        end
    end

    // Gain normalisation: divide by R^(N-1), then clamp to the output range
    assign w_shift = SH_W'(r_log2r * (N_STAGES - 1));

    always_comb begin
`ifdef CIC_INT_ROUND_EN
        w_round = (w_shift != '0) ? (W_ACC'(1) << (w_shift - SH_W'(1))) : '0;
`else
        w_round = '0;
`endif
        w_shifted = (r_int[N_STAGES-1] + w_round) >>> w_shift;
        if (w_shifted > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            w_sat = w_shifted[DATA_WIDTH-1:0];
        end
    end

    // Control, comb taps, zero-stuffing upsampler, integrators and output register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_log2r   <= '0;
            r_phase   <= '0;
            r_fill    <= '0;
            r_u       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            underrun  <= 1'b0;
            for (int k = 0; k < int'(N_STAGES); k++) begin
                r_comb_dly[k] <= '0;
                r_int[k]      <= '0;
            end
        end else if (!filter_enable) begin
            r_state   <= IDLE;
            r_log2r   <= '0;
            r_phase   <= '0;
            r_fill    <= '0;
            r_u       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            underrun  <= 1'b0;
            for (int k = 0; k < int'(N_STAGES); k++) begin
                r_comb_dly[k] <= '0;
                r_int[k]      <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= RUN;
                        r_log2r <= w_fact_log2;
                        r_phase <= '0;
                    end
                end
                RUN: begin
                    r_phase <= w_ph_last ? '0 : r_phase + PH_W'(1);
                    if (r_fill != FILL_W'(N_STAGES)) begin
                        r_fill <= r_fill + FILL_W'(1);
                    end
                end
            endcase

            if (w_comb_clk) begin
                for (int k = 0; k < int'(N_STAGES); k++) begin
                    r_comb_dly[k] <= w_comb[k];
                end
                r_u <= w_comb[N_STAGES];
            end else begin
                r_u <= '0;
            end

            // Pipelined integrators; in IDLE everything is zero so they stay zero
            r_int[0] <= r_int[0] + r_u;
            for (int k = 1; k < int'(N_STAGES); k++) begin
                r_int[k] <= r_int[k] + r_int[k-1];
            end

            underrun  <= (r_state == RUN) && w_ph_last && !w_accept;
            out_valid <= (r_state == RUN) && (r_fill == FILL_W'(N_STAGES));
            out_data  <= w_sat;
        end
    end

endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator
//   Scenario tasks drive low-rate streams into cic_interpolator. Expected output
//   samples come from a direct convolution with the CIC impulse response
//   ((1-z^-R)/(1-z^-1))^N / R^(N-1) and are queued before driving, then popped
//   per output cycle.
module tb_cic_interpolator;

    localparam int DW = 16;
    localparam int NS = 3;
    localparam int LAT = NS + 1;

    logic        CLK = 1'b0;
    logic        RST;
    logic        filter_enable;
    logic [4:0]  fac;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        underrun;
    logic        factor_err;

    int total = 0;
    int bad   = 0;

    int stim_data[$];
    bit stim_valid[$];
    int exp_q[$];
    int rec_out[$];
    bit rec_ur[$];
    bit rec_rdy[$];

    cic_interpolator #(.DATA_WIDTH(DW), .N_STAGES(NS), .LOG2_MAX_R(4)) dut (
        .CLK                      (CLK),
        .RST                      (RST),
        .filter_enable            (filter_enable),
        .CIC_Interpolation_Factor (fac),
        .in_data                  (in_data),
        .in_valid                 (in_valid),
        .in_ready                 (in_ready),
        .out_data                 (out_data),
        .out_valid                (out_valid),
        .underrun                 (underrun),
        .factor_err               (factor_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lg2(input int r);
        int l = 0;
        while ((1 << l) < r) l++;
        return l;
    endfunction

    function automatic bit slot_valid(input int j);
        return (j < stim_valid.size()) ? stim_valid[j] : 1'b1;
    endfunction

    function automatic int slot_data(input int j);
        return (j < stim_data.size()) ? stim_data[j] : 0;
    endfunction

    task automatic set_stim(input int n, input int val);
        stim_data.delete();
        stim_valid.delete();
        for (int i = 0; i < n; i++) begin
            stim_data.push_back(val);
            stim_valid.push_back(1'b1);
        end
    endtask

    // Reference model: per-cycle expected out_data pushed into exp_q
    task automatic build_expected(input int r, input int ncyc);
        longint h[$];
        longint t[$];
        longint x[$];
        longint acc;
        int s;
        int n;
        h.delete();
        h.push_back(1);
        for (int st = 0; st < NS; st++) begin
            t.delete();
            for (int i = 0; i < h.size() + r - 1; i++) t.push_back(0);
            for (int i = 0; i < h.size(); i++)
                for (int k = 0; k < r; k++) t[i+k] += h[i];
            h = t;
        end
        x.delete();
        for (int c = 0; c < ncyc; c++) begin
            if ((c % r == 0) && slot_valid(c / r)) x.push_back(longint'(slot_data(c / r)));
            else x.push_back(0);
        end
        s = lg2(r) * (NS - 1);
        exp_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            if (c < LAT) begin
                exp_q.push_back(0);
            end else begin
                n = c - LAT;
                acc = 0;
                for (int k = 0; k <= n && k < h.size(); k++) acc += h[k] * x[n-k];
`ifdef CIC_INT_ROUND_EN
                if (s > 0) acc += longint'(1) << (s - 1);
`endif
                acc = acc >>> s;
                if (acc > 32767) acc = 32767;
                if (acc < -32768) acc = -32768;
                exp_q.push_back(int'(acc));
            end
        end
    endtask

    // Drives one stream from IDLE (cycle 0 is the accepting edge) and scores it
    task automatic drive_stream(input string tag, input int r, input int ncyc, input int fac_mid);
        int  j;
        int  got;
        int  e;
        bit  er;
        bit  eu;
        bit  ev;
        build_expected(r, ncyc);
        rec_out.delete();
        rec_ur.delete();
        rec_rdy.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge CLK);
            filter_enable = 1'b1;
            fac = (c == 0) ? 5'(r) : 5'(fac_mid);
            j = c / r;
            if (c % r == 0) begin
                in_valid = slot_valid(j);
                in_data  = 16'(slot_data(j));
            end else begin
                in_valid = 1'($urandom_range(1, 0));
                in_data  = 16'($urandom);
            end
            #1;
            er = (c % r == 0);
            total++;
            if (in_ready !== er) begin
                bad++;
                $display("FAIL %s in_ready c=%0d got=%b exp=%b", tag, c, in_ready, er);
            end
            rec_rdy.push_back(in_ready);
            @(posedge CLK);
            #2;
            got = int'($signed(out_data));
            e   = exp_q.pop_front();
            ev  = (c >= LAT);
            eu  = (c > 0) && (c % r == 0) && !slot_valid(j);
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s out_data c=%0d got=%0d exp=%0d", tag, c, got, e);
            end
            total++;
            if (out_valid !== ev) begin
                bad++;
                $display("FAIL %s out_valid c=%0d got=%b exp=%b", tag, c, out_valid, ev);
            end
            total++;
            if (underrun !== eu) begin
                bad++;
                $display("FAIL %s underrun c=%0d got=%b exp=%b", tag, c, underrun, eu);
            end
            rec_out.push_back(got);
            rec_ur.push_back(underrun);
        end
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic go_idle();
        @(negedge CLK);
        filter_enable = 1'b0;
        in_valid      = 1'b0;
        @(negedge CLK);
        filter_enable = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (out_data !== 16'd0) begin bad++; $display("FAIL rst out_data got=%0d exp=0", out_data); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst out_valid got=%b exp=0", out_valid); end
        total++;
        if (underrun !== 1'b0) begin bad++; $display("FAIL rst underrun got=%b exp=0", underrun); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rst in_ready got=%b exp=0", in_ready); end
        total++;
        if (factor_err !== 1'b1) begin bad++; $display("FAIL rst factor_err(R=0) got=%b exp=1", factor_err); end
        RST           = 1'b1;
        filter_enable = 1'b1;
        fac           = 5'd4;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL idle in_ready got=%b exp=1", in_ready); end
        total++;
        if (factor_err !== 1'b0) begin bad++; $display("FAIL idle factor_err got=%b exp=0", factor_err); end
        @(posedge CLK);
        #2;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL idle out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_impulse();
        int ref_v[5];
        ref_v = '{16, 48, 48, 16, 0};
        set_stim(12, 0);
        stim_data[0] = 64;
        drive_stream("impulse", 2, 24, 2);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rec_out[LAT+i] !== ref_v[i]) begin
                bad++;
                $display("FAIL impulse_const idx=%0d got=%0d exp=%0d", i, rec_out[LAT+i], ref_v[i]);
            end
        end
        go_idle();
    endtask

    task automatic test_const();
        int nr = 0;
        set_stim(20, 1000);
        drive_stream("const", 4, 80, 4);
        foreach (rec_rdy[i]) nr += int'(rec_rdy[i]);
        total++;
        if (rec_out[79] !== 1000) begin bad++; $display("FAIL const_settle got=%0d exp=1000", rec_out[79]); end
        total++;
        if (nr !== 20) begin bad++; $display("FAIL const_ready_count got=%0d exp=20", nr); end
        go_idle();
    endtask

    task automatic test_underrun();
        int nu = 0;
        int nr = 0;
        set_stim(8, 0);
        for (int j = 0; j < 8; j++) stim_data[j] = 2000 * (j + 1);
        stim_valid[3] = 1'b0;
        drive_stream("underrun", 16, 128, 16);
        foreach (rec_ur[i]) nu += int'(rec_ur[i]);
        foreach (rec_rdy[i]) nr += int'(rec_rdy[i]);
        total++;
        if (nu !== 1) begin bad++; $display("FAIL underrun_count got=%0d exp=1", nu); end
        total++;
        if (rec_ur[48] !== 1'b1) begin bad++; $display("FAIL underrun_pos got=%b exp=1", rec_ur[48]); end
        total++;
        if (nr !== 8) begin bad++; $display("FAIL underrun_ready_count got=%0d exp=8", nr); end
        go_idle();
    endtask

    task automatic test_factor_err();
        int  fv[10];
        bit  fe[10];
        fv = '{0, 3, 5, 17, 31, 1, 2, 4, 8, 16};
        fe = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            fac      = 5'(fv[i]);
            in_valid = 1'b0;
            #1;
            total++;
            if (factor_err !== fe[i]) begin
                bad++;
                $display("FAIL factor_err R=%0d got=%b exp=%b", fv[i], factor_err, fe[i]);
            end
        end
        @(negedge CLK);
        fac      = 5'd5;
        in_valid = 1'b1;
        in_data  = 16'd123;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL ferr in_ready got=%b exp=0", in_ready); end
        repeat (6) @(posedge CLK);
        #2;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL ferr stays_idle out_valid got=%b exp=0", out_valid); end
        total++;
        if (out_data !== 16'd0) begin bad++; $display("FAIL ferr stays_idle out_data got=%0d exp=0", out_data); end
        @(negedge CLK);
        fac      = 5'd8;
        in_valid = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL ferr_fixed in_ready got=%b exp=1", in_ready); end
        set_stim(6, 0);
        for (int j = 0; j < 6; j++) stim_data[j] = int'($urandom_range(20000, 0)) - 10000;
        drive_stream("ferr_start", 8, 64, 8);
        go_idle();
    endtask

    task automatic test_disable();
        set_stim(10, 3000);
        drive_stream("dis_pre", 4, 30, 4);
        filter_enable = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL dis in_ready got=%b exp=0", in_ready); end
        @(posedge CLK);
        #2;
        total++;
        if (out_data !== 16'd0) begin bad++; $display("FAIL dis out_data got=%0d exp=0", out_data); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL dis out_valid got=%b exp=0", out_valid); end
        total++;
        if (underrun !== 1'b0) begin bad++; $display("FAIL dis underrun got=%b exp=0", underrun); end
        @(negedge CLK);
        filter_enable = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL dis_reenable in_ready got=%b exp=1", in_ready); end
        set_stim(12, 0);
        stim_data[0] = -64;
        drive_stream("dis_restart", 2, 24, 2);
        go_idle();
        set_stim(10, 3000);
        drive_stream("rst_pre", 4, 30, 4);
        #2;
        RST = 1'b0;
        #1;
        total++;
        if (out_data !== 16'd0) begin bad++; $display("FAIL arst out_data got=%0d exp=0", out_data); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL arst out_valid got=%b exp=0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL arst in_ready(IDLE) got=%b exp=1", in_ready); end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_step();
        bit mono = 1'b1;
        int nr = 0;
        set_stim(16, 32767);
        drive_stream("step", 8, 128, 2);
        for (int c = 1; c < 128; c++) if (rec_out[c] < rec_out[c-1]) mono = 1'b0;
        foreach (rec_rdy[i]) nr += int'(rec_rdy[i]);
        total++;
        if (mono !== 1'b1) begin bad++; $display("FAIL step_monotonic got=%b exp=1", mono); end
        total++;
        if (rec_out[127] !== 32767) begin bad++; $display("FAIL step_settle got=%0d exp=32767", rec_out[127]); end
        total++;
        if (nr !== 16) begin bad++; $display("FAIL step_ready_count(R change ignored) got=%0d exp=16", nr); end
        go_idle();
    endtask

    task automatic test_back_to_back();
        set_stim(40, 0);
        for (int j = 0; j < 40; j++) stim_data[j] = int'($urandom_range(65535, 0)) - 32768;
        stim_data[0] = -32768;
        stim_data[1] = 32767;
        drive_stream("r1", 1, 40, 1);
        for (int c = LAT; c < 40; c++) begin
            total++;
            if (rec_out[c] !== stim_data[c-LAT]) begin
                bad++;
                $display("FAIL r1_passthrough c=%0d got=%0d exp=%0d", c, rec_out[c], stim_data[c-LAT]);
            end
        end
        go_idle();
        set_stim(10, 0);
        for (int j = 0; j < 10; j++) stim_data[j] = (j % 2 == 0) ? 32767 : -32768;
        drive_stream("r16_alt", 16, 160, 16);
        go_idle();
    endtask

    initial begin
        RST           = 1'b0;
        filter_enable = 1'b0;
        fac           = 5'd0;
        in_data       = 16'd0;
        in_valid      = 1'b0;
        test_reset();
        test_impulse();
        test_const();
        test_underrun();
        test_factor_err();
        test_disable();
        test_step();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
